// File: rtl/motoro3_step_timer.sv
// Six-step commutation timer: counts each step period down, advances the step index, drives gate enables.
// Latency: LOAD one clock after run is sampled; each step lasts exactly P clocks; phases follow a registered index.
// Backpressure: none. Free-running timer; m3run=0 stops it at the next edge with the index held.
//
// Ports:
//   clk, nRst          - system clock (10 MHz), asynchronous active-low reset
//   m3cnt_reload1      - requested step period in clocks, sampled at LOAD and at each step boundary
//   m3run, m3dir       - run level; direction (0 = forward, 1 = reverse), used at step boundaries
//   m3step_idx         - current commutation step 0..5
//   m3step_pulse       - one-clock pulse in the cycle a new index first appears
//   m3phase_hi/_lo     - high/low side gate enables {W,V,U}, zero during dead time
//   m3cnt_now, m3busy  - live down-counter (debug), high while loading or running
module motoro3_step_timer #(
   parameter int CNT_W = 25,
   parameter int DEADT = 4
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic [CNT_W-1:0] m3cnt_reload1,
   input  logic             m3run,
   input  logic             m3dir,
   output logic [2:0]       m3step_idx,
   output logic             m3step_pulse,
   output logic [2:0]       m3phase_hi,
   output logic [2:0]       m3phase_lo,
   output logic [CNT_W-1:0] m3cnt_now,
   output logic             m3busy
);

   localparam int               DT_W    = (DEADT < 1) ? 1 : $clog2(DEADT + 1);
   localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(DEADT + 2);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [DT_W-1:0]  DT_LOAD = DT_W'(DEADT);
   localparam logic [DT_W-1:0]  DT_ONE  = DT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic [DT_W-1:0]  dt_q, dt_d;

   logic [CNT_W-1:0] p_eff;
   logic [2:0]       idx_next;
   logic [2:0]       tbl_hi, tbl_lo;

   // Short periods are clamped so every step keeps at least two active clocks after dead time.
   assign p_eff = (m3cnt_reload1 < MIN_P) ? MIN_P : m3cnt_reload1;

   assign idx_next = m3dir ? ((idx_q == 3'd0) ? 3'd5 : idx_q - 3'd1)
                           : ((idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pulse_d = 1'b0;
      cnt_d   = cnt_q;
      per_d   = per_q;
      dt_d    = dt_q;
      case (state_q)
         ST_IDLE: begin
            if (m3run) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (!m3run) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               dt_d    = '0;
            end else begin
               state_d = ST_RUN;
               per_d   = p_eff;
               cnt_d   = p_eff - CNT_ONE;
               dt_d    = DT_LOAD;
            end
         end
         ST_RUN: begin
            if (!m3run) begin
               // Stop has priority over a coincident step boundary: no advance, no pulse.
               state_d = ST_IDLE;
               cnt_d   = '0;
               dt_d    = '0;
            end else if (cnt_q == '0) begin
               per_d   = p_eff;
               cnt_d   = p_eff - CNT_ONE;
               idx_d   = idx_next;
               pulse_d = 1'b1;
               dt_d    = DT_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
               if (dt_q != '0) dt_d = dt_q - DT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= ST_IDLE;
         idx_q   <= 3'd0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
         per_q   <= '0;
         dt_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         dt_q    <= dt_d;
      end
   end

   // Commutation table: one high side and one different low side per step.
   always_comb begin
      tbl_hi = 3'b000;
      tbl_lo = 3'b000;
      case (idx_q)
         3'd0: begin tbl_hi = 3'b001; tbl_lo = 3'b010; end
         3'd1: begin tbl_hi = 3'b001; tbl_lo = 3'b100; end
         3'd2: begin tbl_hi = 3'b010; tbl_lo = 3'b100; end
         3'd3: begin tbl_hi = 3'b010; tbl_lo = 3'b001; end
         3'd4: begin tbl_hi = 3'b100; tbl_lo = 3'b001; end
         3'd5: begin tbl_hi = 3'b100; tbl_lo = 3'b010; end
         default: begin tbl_hi = 3'b000; tbl_lo = 3'b000; end
      endcase
   end

   // Gating on RUN keeps LOAD and IDLE dark and makes reset/stop blank the gates immediately.
   assign m3phase_hi   = (state_q == ST_RUN && dt_q == '0) ? tbl_hi : 3'b000;
   assign m3phase_lo   = (state_q == ST_RUN && dt_q == '0) ? tbl_lo : 3'b000;
   assign m3step_idx   = idx_q;
   assign m3step_pulse = pulse_q;
   assign m3cnt_now    = cnt_q;
   assign m3busy       = (state_q == ST_LOAD) || (state_q == ST_RUN);

endmodule

// File: tb/tb_motoro3_step_timer.sv
module tb_motoro3_step_timer;

   localparam int CNT_W = 25;
   localparam int DEADT = 4;

   logic             clk;
   logic             nRst;
   logic [CNT_W-1:0] m3cnt_reload1;
   logic             m3run;
   logic             m3dir;
   logic [2:0]       m3step_idx;
   logic             m3step_pulse;
   logic [2:0]       m3phase_hi;
   logic [2:0]       m3phase_lo;
   logic [CNT_W-1:0] m3cnt_now;
   logic             m3busy;

   motoro3_step_timer #(.CNT_W(CNT_W), .DEADT(DEADT)) dut (
      .clk          (clk),
      .nRst         (nRst),
      .m3cnt_reload1(m3cnt_reload1),
      .m3run        (m3run),
      .m3dir        (m3dir),
      .m3step_idx   (m3step_idx),
      .m3step_pulse (m3step_pulse),
      .m3phase_hi   (m3phase_hi),
      .m3phase_lo   (m3phase_lo),
      .m3cnt_now    (m3cnt_now),
      .m3busy       (m3busy)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   typedef struct {
      logic [2:0] hi;
      logic [2:0] lo;
   } phase_t;

   typedef struct {
      int   reload;
      logic dir;
      int   nsteps;
   } scen_t;

   typedef struct {
      logic [2:0] idx;
      int         period;
   } exp_t;

   phase_t tbl [6];
   scen_t  scen [5];
   exp_t   sb [$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int clamp_p(input int r);
      return (r < DEADT + 2) ? DEADT + 2 : r;
   endfunction

   function automatic logic [2:0] step_idx(input logic [2:0] i, input logic dir);
      if (dir) return (i == 3'd0) ? 3'd5 : i - 3'd1;
      return (i == 3'd5) ? 3'd0 : i + 3'd1;
   endfunction

   // Monitor: pops expected steps on each pulse, checks step spacing, dead-time gap and table.
   int   cyc = 0;
   int   last_evt = 0;
   int   since = 0;
   bit   in_run = 0;
   bit   load_cyc = 0;
   bit   prev_busy = 0;
   exp_t e;

   always @(negedge clk) begin
      cyc++;
      chk("hi_and_lo", 32'(m3phase_hi & m3phase_lo), 32'd0);
      if (!m3busy) begin
         in_run   = 0;
         load_cyc = 0;
         chk("phase_idle", 32'({m3phase_hi, m3phase_lo}), 32'd0);
      end else if (!prev_busy) begin
         load_cyc = 1;
         chk("phase_load", 32'({m3phase_hi, m3phase_lo}), 32'd0);
      end else if (load_cyc) begin
         load_cyc = 0;
         in_run   = 1;
         since    = 0;
         last_evt = cyc;
      end
      if (m3step_pulse) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("step_idx", 32'(m3step_idx), 32'(e.idx));
            if (e.period != 0) chk("step_period", 32'(cyc - last_evt), 32'(e.period));
         end
         last_evt = cyc;
         since    = 0;
      end
      if (in_run && m3busy) begin
         if (since < DEADT) chk("dead_gap", 32'({m3phase_hi, m3phase_lo}), 32'd0);
         else chk("phase_tbl", 32'({m3phase_hi, m3phase_lo}),
                  32'({tbl[m3step_idx].hi, tbl[m3step_idx].lo}));
         since++;
      end
      prev_busy = m3busy;
   end

   task automatic wait_pulse();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (m3step_pulse) return;
      end
      chk("pulse_timeout", 32'd0, 32'd1);
   endtask

   logic [2:0] cur_idx;
   int         cur_per;
   int         newp;

   initial begin
      tbl[0] = '{hi: 3'b001, lo: 3'b010};
      tbl[1] = '{hi: 3'b001, lo: 3'b100};
      tbl[2] = '{hi: 3'b010, lo: 3'b100};
      tbl[3] = '{hi: 3'b010, lo: 3'b001};
      tbl[4] = '{hi: 3'b100, lo: 3'b001};
      tbl[5] = '{hi: 3'b100, lo: 3'b010};
      scen[0] = '{reload: 10, dir: 1'b0, nsteps: 12};
      scen[1] = '{reload: 20, dir: 1'b0, nsteps: 2};
      scen[2] = '{reload: 0,  dir: 1'b0, nsteps: 3};
      scen[3] = '{reload: 1,  dir: 1'b1, nsteps: 3};
      scen[4] = '{reload: 7,  dir: 1'b1, nsteps: 2};

      nRst = 1'b1;
      m3run = 1'b0;
      m3dir = 1'b0;
      m3cnt_reload1 = CNT_W'(10);
      #5 nRst = 1'b0;
      #5;
      chk("rst_idx",   32'(m3step_idx), 32'd0);
      chk("rst_pulse", 32'(m3step_pulse), 32'd0);
      chk("rst_hi",    32'(m3phase_hi), 32'd0);
      chk("rst_lo",    32'(m3phase_lo), 32'd0);
      chk("rst_cnt",   32'(m3cnt_now), 32'd0);
      chk("rst_busy",  32'(m3busy), 32'd0);

      repeat (2) @(negedge clk);
      nRst = 1'b1;
      @(negedge clk);
      m3run = 1'b1;
      sb.push_back('{idx: 3'd1, period: 10});
      @(negedge clk);
      chk("load_busy", 32'(m3busy), 32'd1);
      @(negedge clk);
      chk("run_cnt_start", 32'(m3cnt_now), 32'd9);
      chk("run_idx_start", 32'(m3step_idx), 32'd0);
      wait_pulse();
      cur_idx = 3'd1;
      cur_per = 10;

      // Each row changes reload/dir mid-step; the step in flight keeps the old period.
      for (int r = 0; r < 5; r++) begin
         repeat (3) @(negedge clk);
         m3cnt_reload1 = CNT_W'(scen[r].reload);
         m3dir = scen[r].dir;
         newp = clamp_p(scen[r].reload);
         for (int s = 0; s < scen[r].nsteps; s++) begin
            cur_idx = step_idx(cur_idx, scen[r].dir);
            sb.push_back('{idx: cur_idx, period: (s == 0) ? cur_per : newp});
         end
         cur_per = newp;
         for (int s = 0; s < scen[r].nsteps; s++) wait_pulse();
      end

      // Stop coinciding with the step boundary: index held, no pulse.
      repeat (6) @(negedge clk);
      chk("stop_cnt_zero", 32'(m3cnt_now), 32'd0);
      m3run = 1'b0;
      @(negedge clk);
      chk("stop_busy",  32'(m3busy), 32'd0);
      chk("stop_pulse", 32'(m3step_pulse), 32'd0);
      chk("stop_idx",   32'(m3step_idx), 32'(cur_idx));
      chk("stop_cnt",   32'(m3cnt_now), 32'd0);
      chk("stop_phase", 32'({m3phase_hi, m3phase_lo}), 32'd0);
      repeat (10) @(negedge clk);

      // Restart resumes at the held index.
      m3dir = 1'b0;
      m3cnt_reload1 = CNT_W'(10);
      m3run = 1'b1;
      sb.push_back('{idx: step_idx(cur_idx, 1'b0), period: 10});
      sb.push_back('{idx: step_idx(step_idx(cur_idx, 1'b0), 1'b0), period: 10});
      @(negedge clk);
      chk("rerun_load_busy", 32'(m3busy), 32'd1);
      @(negedge clk);
      chk("rerun_idx", 32'(m3step_idx), 32'(cur_idx));
      chk("rerun_cnt", 32'(m3cnt_now), 32'd9);
      wait_pulse();
      wait_pulse();
      chk("pre_rst_idx", 32'(m3step_idx), 32'd3);

      // Asynchronous reset mid-step while the gates are active.
      repeat (6) @(negedge clk);
      chk("pre_rst_active", 32'(m3phase_hi != 3'b000), 32'd1);
      #5 nRst = 1'b0;
      #1;
      chk("arst_idx",   32'(m3step_idx), 32'd0);
      chk("arst_pulse", 32'(m3step_pulse), 32'd0);
      chk("arst_phase", 32'({m3phase_hi, m3phase_lo}), 32'd0);
      chk("arst_cnt",   32'(m3cnt_now), 32'd0);
      chk("arst_busy",  32'(m3busy), 32'd0);
      m3run = 1'b0;
      @(negedge clk);
      nRst = 1'b1;
      @(negedge clk);
      m3run = 1'b1;
      sb.push_back('{idx: 3'd1, period: 10});
      @(negedge clk);
      @(negedge clk);
      chk("after_rst_idx", 32'(m3step_idx), 32'd0);
      wait_pulse();
      repeat (3) @(negedge clk);
      m3run = 1'b0;
      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
